if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
// - Instruction-fetch stage (pre-IF + IF) of the LA32R 5-stage pipeline; producer side of the
//   fs->ds handshake whose consumer is the decode stage.
// - Generates next PC, drives synchronous inst SRAM (1-cycle read latency), holds fetched
//   instruction in a 1-entry skid buffer while decode stalls, redirects on br_taken_cancel.
// - Flags misaligned fetch addresses (ADEF) instead of accessing SRAM.
// PARAMETERS
// - RESET_PC   32'h1c000000   address of first fetch after reset release
// PORTS
// - clk              in   1   clock, all state on posedge
// - reset            in   1   reset, asynchronous, active-high
// - ds_allow_in      in   1   decode can accept an instruction this cycle
// - br_taken_cancel  in   1   decode redirects fetch; already qualified by decode valid
// - br_target        in   32  redirect target PC
// - inst_sram_en     out  1   SRAM read request this cycle
// - inst_sram_we     out  4   tied 4'b0
// - inst_sram_addr   out  32  read address (= nextpc)
// - inst_sram_wdata  out  32  tied 32'b0
// - inst_sram_rdata  in   32  read data, valid only in cycle after request
// - fs_to_ds_valid   out  1   IF holds a valid instruction for decode
// - fs_pc            out  32  PC of instruction in IF
// - fs_inst          out  32  instruction in IF
// - fs_adef          out  1   instruction in IF has misaligned PC (fs_inst forced 0)
// BEHAVIOUR
// - Reset (async): started=0, fs_valid=0, fs_pc=RESET_PC-4, fs_adef=0, buf_valid=0, inst_buf=0.
//   Outputs during/after reset until first fetch: en=0, valid=0, fs_pc=RESET_PC-4, fs_inst=rdata.
// - started<=1 on first posedge after reset deassert; no request while started=0.
// - fs_ready_go=1. fs_allow_in = !fs_valid | ds_allow_in | br_taken_cancel.
// - nextpc = br_taken_cancel ? br_target : fs_pc+4 (32-bit modulo, FFFFFFFC+4 -> 00000000).
// - misalign = |nextpc[1:0]. inst_sram_addr = nextpc (always driven).
// - inst_sram_en = started & fs_allow_in & !misalign.
// - Advance (posedge, started & fs_allow_in): fs_pc<=nextpc, fs_valid<=1, fs_adef<=misalign,
//   buf_valid<=0. Fetch latency: request cycle N -> fs_pc/fs_inst valid in cycle N+1.
// - Skid capture (no advance, fs_valid & !ds_allow_in & !buf_valid & !fs_adef):
//   inst_buf<=inst_sram_rdata, buf_valid<=1. Captures in the first stall cycle, the only cycle
//   rdata is guaranteed; held instruction then stable for any stall length.
// - fs_inst = fs_adef ? 32'b0 : buf_valid ? inst_buf : inst_sram_rdata.
// - fs_to_ds_valid = fs_valid & !br_taken_cancel (wrong-path instruction never handed over).
// - Branch cancel: wrong-path IF entry dropped same cycle; redirect always accepted even if
//   decode stalls (fs_allow_in forced 1); buffer cleared; target fetched next cycle.
// - Cancel with started=0: ignored. Simultaneous stall+cancel: cancel wins.
// - Handoff: instruction transfers on a cycle with fs_to_ds_valid & ds_allow_in; each fetched
//   PC delivered exactly once, in order, unless cancelled.
// - Reset mid-operation: all state cleared immediately; outstanding SRAM read data ignored;
//   fetch restarts at RESET_PC.
// TESTING
// - Reset release, ds_allow_in=1 -> addr 1c000000,1c000004,1c000008 on consecutive cycles;
//   fs_pc follows one cycle later with matching rdata.
// - Stall 3 cycles with fs_pc=1c000008 -> en=0, fs_inst equals captured word all 3 cycles
//   although rdata driven with garbage; then resumes at 1c00000c.
// - br_taken_cancel, target=1c000100, while fs_pc=1c000010 -> fs_to_ds_valid=0 that cycle,
//   addr=1c000100, next fs_pc=1c000100; 1c000010 never transferred.
// - Cancel during stall (ds_allow_in=0, buf_valid=1), target=1c000200 -> buffer dropped,
//   next fs_pc=1c000200.
// - Cancel target 1c000302 -> en=0, next cycle fs_adef=1, fs_inst=0, fs_pc=1c000302.
// - Cancel target FFFFFFFC -> next request addr 00000000; reset asserted mid-stall ->
//   fs_valid=0 immediately, first request after release at 1c000000.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// ============================================================================
// Module   : if_fetch_stage_if
// Brief    : Fetch-stage bundle: decode handshake/redirect plus inst SRAM port.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface if_fetch_stage_if;
    logic        ds_allow_in;
    logic        br_taken_cancel;
    logic [31:0] br_target;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_adef;

    modport master (
        input  ds_allow_in, br_taken_cancel, br_target, inst_sram_rdata,
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output fs_to_ds_valid, fs_pc, fs_inst, fs_adef
    );

    modport slave (
        output ds_allow_in, br_taken_cancel, br_target, inst_sram_rdata,
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  fs_to_ds_valid, fs_pc, fs_inst, fs_adef
    );
endinterface

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module   : if_fetch_stage
// Brief    : LA32R pre-IF/IF stage with 1-entry skid buffer and ADEF detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    if_fetch_stage_if.master  bus
);

    logic        r_started;
    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic        r_fs_adef;
    logic        r_buf_valid;
    logic [31:0] r_inst_buf;

    logic        w_fs_allow_in;
    logic [31:0] w_nextpc;
    logic        w_misalign;
    logic        w_advance;
    logic        w_capture;

    // A redirect is always accepted, even against a stalled decode stage.
    assign w_fs_allow_in = !r_fs_valid || bus.ds_allow_in || bus.br_taken_cancel;
    assign w_nextpc      = bus.br_taken_cancel ? bus.br_target : (r_fs_pc + 32'd4);
    assign w_misalign    = |w_nextpc[1:0];
    assign w_advance     = r_started && w_fs_allow_in;
    // rdata is only guaranteed in the first stall cycle, so grab it there.
    assign w_capture     = !w_advance && r_fs_valid && !bus.ds_allow_in
                           && !r_buf_valid && !r_fs_adef;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_started   <= 1'b0;
            r_fs_valid  <= 1'b0;
            r_fs_pc     <= RESET_PC - 32'd4;
            r_fs_adef   <= 1'b0;
            r_buf_valid <= 1'b0;
            r_inst_buf  <= 32'd0;
        end else begin
            r_started <= 1'b1;
            if (w_advance) begin
                r_fs_pc     <= w_nextpc;
                r_fs_valid  <= 1'b1;
                r_fs_adef   <= w_misalign;
                r_buf_valid <= 1'b0;
            end else if (w_capture) begin
                r_inst_buf  <= bus.inst_sram_rdata;
                r_buf_valid <= 1'b1;
            end
        end
    end

    assign bus.inst_sram_en    = r_started && w_fs_allow_in && !w_misalign;
    assign bus.inst_sram_we    = 4'b0000;
    assign bus.inst_sram_addr  = w_nextpc;
    assign bus.inst_sram_wdata = 32'd0;

    assign bus.fs_to_ds_valid = r_fs_valid && !bus.br_taken_cancel;
    assign bus.fs_pc          = r_fs_pc;
    assign bus.fs_adef        = r_fs_adef;
    assign bus.fs_inst        = r_fs_adef   ? 32'd0 :
                                r_buf_valid ? r_inst_buf : bus.inst_sram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Directed vector table plus randomized run against a PC-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;
    localparam logic [31:0] C_RESET_PC = 32'h1c00_0000;
    localparam logic [31:0] C_PRE_PC   = C_RESET_PC - 32'd4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(C_RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction content is a fixed function of its address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a_1234;
    endfunction

    // Synchronous SRAM: valid data one cycle after a request, garbage otherwise.
    always @(posedge clk) begin
        if (bus.inst_sram_en)
            bus.inst_sram_rdata <= memf(bus.inst_sram_addr);
        else
            bus.inst_sram_rdata <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ds;
        logic        cancel;
        logic [31:0] tgt;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        adef;
    } vec_t;

    function automatic vec_t mk(input logic ds, input logic cancel, input logic [31:0] tgt,
                                input logic en, input logic [31:0] addr, input logic valid,
                                input logic [31:0] pc, input logic adef);
        vec_t v;
        v.ds = ds; v.cancel = cancel; v.tgt = tgt; v.en = en;
        v.addr = addr; v.valid = valid; v.pc = pc; v.adef = adef;
        return v;
    endfunction

    vec_t vecs [17];

    // Reference model state: what is architecturally in IF.
    logic        m_started;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_adef;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.ds_allow_in     = 1'b0;
        bus.br_taken_cancel = 1'b0;
        bus.br_target       = 32'd0;
        bus.inst_sram_rdata = 32'd0;

        vecs[0]  = mk(1, 0, 0,             0, 32'h1c000000, 0, C_PRE_PC,     0);
        vecs[1]  = mk(1, 0, 0,             1, 32'h1c000000, 0, C_PRE_PC,     0);
        vecs[2]  = mk(1, 0, 0,             1, 32'h1c000004, 1, 32'h1c000000, 0);
        vecs[3]  = mk(1, 0, 0,             1, 32'h1c000008, 1, 32'h1c000004, 0);
        vecs[4]  = mk(0, 0, 0,             0, 32'h1c00000c, 1, 32'h1c000008, 0);
        vecs[5]  = mk(0, 0, 0,             0, 32'h1c00000c, 1, 32'h1c000008, 0);
        vecs[6]  = mk(0, 0, 0,             0, 32'h1c00000c, 1, 32'h1c000008, 0);
        vecs[7]  = mk(1, 0, 0,             1, 32'h1c00000c, 1, 32'h1c000008, 0);
        vecs[8]  = mk(1, 0, 0,             1, 32'h1c000010, 1, 32'h1c00000c, 0);
        vecs[9]  = mk(1, 1, 32'h1c000100,  1, 32'h1c000100, 0, 32'h1c000010, 0);
        vecs[10] = mk(1, 0, 0,             1, 32'h1c000104, 1, 32'h1c000100, 0);
        vecs[11] = mk(0, 0, 0,             0, 32'h1c000108, 1, 32'h1c000104, 0);
        vecs[12] = mk(0, 1, 32'h1c000200,  1, 32'h1c000200, 0, 32'h1c000104, 0);
        vecs[13] = mk(1, 1, 32'h1c000302,  0, 32'h1c000302, 0, 32'h1c000200, 0);
        vecs[14] = mk(1, 1, 32'hfffffffc,  1, 32'hfffffffc, 0, 32'h1c000302, 1);
        vecs[15] = mk(1, 0, 0,             1, 32'h00000000, 1, 32'hfffffffc, 0);
        vecs[16] = mk(0, 0, 0,             0, 32'h00000004, 1, 32'h00000000, 0);

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_en",    {31'd0, bus.inst_sram_en},   32'd0);
        chk("rst_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);
        chk("rst_pc",    bus.fs_pc,                   C_PRE_PC);
        chk("rst_adef",  {31'd0, bus.fs_adef},        32'd0);
        chk("rst_inst",  bus.fs_inst,                 bus.inst_sram_rdata);
        chk("rst_we",    {28'd0, bus.inst_sram_we},   32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            bus.ds_allow_in     = vecs[i].ds;
            bus.br_taken_cancel = vecs[i].cancel;
            bus.br_target       = vecs[i].tgt;
            #1;
            chk($sformatf("v%0d_en", i),    {31'd0, bus.inst_sram_en},   {31'd0, vecs[i].en});
            chk($sformatf("v%0d_addr", i),  bus.inst_sram_addr,          vecs[i].addr);
            chk($sformatf("v%0d_valid", i), {31'd0, bus.fs_to_ds_valid}, {31'd0, vecs[i].valid});
            chk($sformatf("v%0d_pc", i),    bus.fs_pc,                   vecs[i].pc);
            chk($sformatf("v%0d_adef", i),  {31'd0, bus.fs_adef},        {31'd0, vecs[i].adef});
            if (i >= 2)
                chk($sformatf("v%0d_inst", i), bus.fs_inst,
                    vecs[i].adef ? 32'd0 : memf(vecs[i].pc));
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a stall.
        bus.ds_allow_in     = 1'b0;
        bus.br_taken_cancel = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);
        chk("arst_en",    {31'd0, bus.inst_sram_en},   32'd0);
        chk("arst_pc",    bus.fs_pc,                   C_PRE_PC);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        m_started = 1'b0;
        m_valid   = 1'b0;
        m_pc      = C_PRE_PC;
        m_adef    = 1'b0;

        for (int c = 0; c < 400; c++) begin
            logic        x_allow;
            logic [31:0] x_next;
            logic        x_mis;
            bus.ds_allow_in     = ($urandom_range(3) != 0);
            bus.br_taken_cancel = ($urandom_range(7) == 0);
            case ($urandom_range(5))
                0:       bus.br_target = 32'hfffffffc;
                1:       bus.br_target = {16'h1c00, 14'($urandom), 2'($urandom)};
                default: bus.br_target = {16'h1c00, 14'($urandom), 2'b00};
            endcase
            x_allow = !m_valid || bus.ds_allow_in || bus.br_taken_cancel;
            x_next  = bus.br_taken_cancel ? bus.br_target : m_pc + 32'd4;
            x_mis   = (x_next % 4) != 0;
            #1;
            chk("r_en",    {31'd0, bus.inst_sram_en},
                {31'd0, m_started && x_allow && !x_mis});
            chk("r_addr",  bus.inst_sram_addr, x_next);
            chk("r_valid", {31'd0, bus.fs_to_ds_valid},
                {31'd0, m_valid && !bus.br_taken_cancel});
            chk("r_pc",    bus.fs_pc, m_pc);
            chk("r_adef",  {31'd0, bus.fs_adef}, {31'd0, m_adef});
            if (m_valid)
                chk("r_inst", bus.fs_inst, m_adef ? 32'd0 : memf(m_pc));
            @(posedge clk);
            if (m_started && x_allow) begin
                m_pc    = x_next;
                m_valid = 1'b1;
                m_adef  = x_mis;
            end
            m_started = 1'b1;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
